pipeline_stage_ctrl: RTL
========================

Name: pipeline_stage_ctrl

Overview:
Central stall/flush/halt sequencer for an N-stage in-order pipeline. It replaces the scattered per-stage valid/hazard wiring with one parametrised controller. The controller generates a per-stage advance enable, a per-stage squash, and a bubble-insert strobe. It supports single-step debug, drains the back end after a halt, and maintains a cycle counter. Sits beside the pipeline top; the hazard unit, the decode halt/branch outputs and the debug host drive its inputs.

Parameters:
N_STAGES, 5, number of pipeline stages, index 0 = fetch; legal 3..16
HAZARD_STAGE, 1, index of the stage that detects hazards/halt; legal 1..N_STAGES-2
NB_COUNTER, 32, width of the cycle counter

Ports:
i_clock  in  1  clock
i_reset  in  1  reset; asynchronous, active-low
i_valid  in  1  global run enable
i_step_mode  in  1  1 = advance only on i_step
i_step  in  1  single-cycle step pulse
i_hazard  in  1  load-use stall request from HAZARD_STAGE
i_flush  in  1  taken branch/jump resolved in HAZARD_STAGE
i_halt  in  1  halt instruction present in HAZARD_STAGE
o_stage_en  out  N_STAGES  per-stage register enable
o_stage_flush  out  N_STAGES  per-stage squash (load NOP)
o_bubble  out  1  insert NOP into stage HAZARD_STAGE+1
o_state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3
o_done  out  1  pipeline fully drained
o_n_clocks  out  NB_COUNTER  advancing-cycle count

Behaviour:
- adv = i_valid & (~i_step_mode | i_step). Combinational; i_step is not edge-detected, so each high cycle is one step.
- Front = stages 0..HAZARD_STAGE. Back = stages HAZARD_STAGE+1..N_STAGES-1. DRAIN_LEN = N_STAGES-1-HAZARD_STAGE.
- Reset (i_reset=0, async): state=IDLE, drain counter=0, o_n_clocks=0, o_done=0. All combinational outputs evaluate to 0 in IDLE.
- IDLE: all outputs 0. Moves to RUN on the first clock with i_valid=1; that cycle is not counted and enables nothing.
- RUN, adv=0: o_stage_en=0, no flush, no bubble (pipeline frozen).
- RUN, adv=1, priority hazard > halt > flush:
  - i_hazard: front en=0, back en=1, o_bubble=1. Any concurrent halt or flush is ignored this cycle; the source re-presents it next cycle because the front is held.
  - i_halt: all en=1 and o_bubble=1, so the halt instruction itself is discarded. Next state DRAIN, drain counter=DRAIN_LEN.
  - i_flush: all en=1, o_stage_flush[0..HAZARD_STAGE-1]=1.
  - none: all en=1.
- DRAIN: front en=0 always. On adv, back en=1, counter decrements, and o_bubble=1 so NOPs fill behind. When adv=1 and counter==1, the next state is DONE. i_hazard, i_flush and i_halt are ignored.
- DONE: all en=0, o_done=1 (registered). Exit only via reset.
- o_n_clocks: +1 on every adv cycle in RUN or DRAIN. It saturates at all-ones with no wrap and holds in IDLE and DONE.
- o_state and o_done are registered. o_stage_en, o_stage_flush and o_bubble are combinational from state and inputs.
- i_step_mode may change any cycle and takes effect on the same cycle.
- Reset mid-DRAIN returns to IDLE; the counter is cleared.

Optional Feature:
STAGE_CTRL_PERF_EN
- Defined: adds outputs o_n_stalls and o_n_flushes, each NB_COUNTER wide. They count accepted hazard cycles and accepted flush cycles respectively (same adv and priority rules), saturate, and reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults (N_STAGES=5, HAZARD_STAGE=1): release reset, hold i_valid=1 for 10 cycles → IDLE for 1 cycle, then o_stage_en=5'b11111 for 9 cycles, o_n_clocks=9.
2. In RUN, assert i_hazard and i_flush together for 1 cycle → o_stage_en=5'b11100, o_bubble=1, o_stage_flush=0. Next cycle i_flush alone → o_stage_flush=5'b00001.
3. Assert i_halt in RUN → same cycle o_bubble=1. Then 3 DRAIN cycles with o_stage_en=5'b11100. o_state=3 and o_done=1 on the following cycle; o_n_clocks frozen afterwards.
4. i_step_mode=1, two i_step pulses 4 cycles apart → o_stage_en nonzero on exactly 2 cycles, o_n_clocks increments by 2.
5. NB_COUNTER=4: run 20 adv cycles → o_n_clocks saturates at 15.
6. Reset asserted during DRAIN (counter=2) → immediately o_state=0, o_stage_en=0, o_n_clocks=0. With STAGE_CTRL_PERF_EN defined, o_n_stalls=0.

Source files
------------

// File: rtl/pipeline_stage_ctrl.sv
// Stall/flush/halt sequencer for an N-stage in-order pipeline: per-stage enables, squash, bubble, drain after halt.
// Optional performance counters (o_n_stalls, o_n_flushes) are built when STAGE_CTRL_PERF_EN is defined.
//
//   state | meaning
//   IDLE  | out of reset, waiting for the first i_valid; all outputs 0
//   RUN   | normal issue; hazard > halt > flush priority on advancing cycles
//   DRAIN | front frozen, back end advances with bubbles until the halt has left
//   DONE  | pipeline empty, o_done=1; exit only through reset
module pipeline_stage_ctrl #(
  parameter int N_STAGES     = 5,
  parameter int HAZARD_STAGE = 1,
  parameter int NB_COUNTER   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_hazard,
  input  logic                  i_flush,
  input  logic                  i_halt,
  output logic [N_STAGES-1:0]   o_stage_en,
  output logic [N_STAGES-1:0]   o_stage_flush,
  output logic                  o_bubble,
  output logic [1:0]            o_state,
  output logic                  o_done,
`ifdef STAGE_CTRL_PERF_EN
  output logic [NB_COUNTER-1:0] o_n_stalls,
  output logic [NB_COUNTER-1:0] o_n_flushes,
`endif
  output logic [NB_COUNTER-1:0] o_n_clocks
);

  localparam int CW = $clog2(N_STAGES);
  localparam logic [CW-1:0] DRAIN_LEN = CW'(N_STAGES - 1 - HAZARD_STAGE);

  localparam logic [N_STAGES-1:0] ALL_MASK   = '1;
  localparam logic [N_STAGES-1:0] FRONT_MASK = ALL_MASK >> (N_STAGES - 1 - HAZARD_STAGE);
  localparam logic [N_STAGES-1:0] BACK_MASK  = ~FRONT_MASK;
  // Squash only the stages strictly younger than the resolving stage.
  localparam logic [N_STAGES-1:0] SQUASH_MASK = ALL_MASK >> (N_STAGES - HAZARD_STAGE);

  localparam logic [NB_COUNTER-1:0] CNT_MAX = '1;
  localparam logic [NB_COUNTER-1:0] CNT_ONE = NB_COUNTER'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
  logic            adv;
  logic            count_adv;
  logic            stall_evt;
  logic            flush_evt;
  logic [NB_COUNTER-1:0] n_clocks;

  assign adv = i_valid & (~i_step_mode | i_step);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    o_stage_en    = '0;
    o_stage_flush = '0;
    o_bubble      = 1'b0;
    count_adv     = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) state_nxt = RUN;
      end
      RUN: begin
        if (adv) begin
          count_adv = 1'b1;
          if (i_hazard) begin
            // Front holds, so a concurrent halt/flush is re-presented next cycle.
            o_stage_en = BACK_MASK;
            o_bubble   = 1'b1;
            stall_evt  = 1'b1;
          end else if (i_halt) begin
            o_stage_en    = ALL_MASK;
            o_bubble      = 1'b1;
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LEN;
          end else if (i_flush) begin
            o_stage_en    = ALL_MASK;
            o_stage_flush = SQUASH_MASK;
            flush_evt     = 1'b1;
          end else begin
            o_stage_en = ALL_MASK;
          end
        end
      end
      DRAIN: begin
        if (adv) begin
          count_adv     = 1'b1;
          o_stage_en    = BACK_MASK;
          o_bubble      = 1'b1;
          drain_cnt_nxt = drain_cnt - CW'(1);
          if (drain_cnt == CW'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      o_done    <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      n_clocks <= '0;
    end else if (count_adv && n_clocks != CNT_MAX) begin
      n_clocks <= n_clocks + CNT_ONE;
    end
  end

  assign o_state    = state;
  assign o_n_clocks = n_clocks;

`ifdef STAGE_CTRL_PERF_EN
  logic [NB_COUNTER-1:0] n_stalls, n_flushes;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      n_stalls  <= '0;
      n_flushes <= '0;
    end else begin
      if (stall_evt && n_stalls != CNT_MAX)  n_stalls  <= n_stalls + CNT_ONE;
      if (flush_evt && n_flushes != CNT_MAX) n_flushes <= n_flushes + CNT_ONE;
    end
  end

  assign o_n_stalls  = n_stalls;
  assign o_n_flushes = n_flushes;
`else
  logic unused_perf;
  assign unused_perf = stall_evt ^ flush_evt;
`endif

endmodule
